// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse receiver: frame FSM states,
// register decode, STATUS bit positions and the timeout divisor.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    // adr[2] selects the register
    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int ST_OVF    = 4;
    localparam int ST_ERR    = 5;
    localparam int ST_INT_EN = 8;

    // CLKFREQ / TIMEOUT_DIV cycles is 2 ms
    localparam int TIMEOUT_DIV = 500;

    typedef struct packed {
        logic [7:0] b2;
        logic [7:0] b1;
        logic [7:0] b0;
    } pkt_t;

endpackage

// File: rtl/if_wb.sv
// Minimal Wishbone bus bundle as seen by an IO-bus decoder port.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;

    modport slave  (input cyc, stb, we, adr, sel, dat_i, output dat_o, ack);
    modport master (output cyc, stb, we, adr, sel, dat_i, input dat_o, ack);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes the mouse clock/data, shifts in an
// 11-bit frame on falling edges and flags good or broken bytes.
module ps2_rx_frame
    import ps2_mouse_pkg::*;
#(
    parameter int CLKFREQ = 10000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       good,
    output logic       bad
);

    localparam int TMO = CLKFREQ / TIMEOUT_DIV;
    localparam int TW  = $clog2(TMO + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic          fall;
    logic          tmo;
    rx_state_t     state;
    rx_state_t     state_nxt;
    logic [9:0]    shreg;
    logic [3:0]    bitcnt;
    logic [TW-1:0] tmr;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clock};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall = clk_prev & ~clk_sync[1];
    assign tmo  = (state == SHIFT) && !fall && (tmr == TW'(TMO - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        good      = 1'b0;
        bad       = 1'b0;
        case (state)
            IDLE:  if (fall && !dat_sync[1]) state_nxt = SHIFT;
            SHIFT: begin
                if (tmo) begin
                    state_nxt = IDLE;
                    bad       = 1'b1;
                end else if (fall && bitcnt == 4'd9) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
                // shreg = {stop, parity, d7..d0}
                if ((^shreg[8:0]) && shreg[9]) good = 1'b1;
                else                           bad  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            shreg  <= '0;
            bitcnt <= '0;
            tmr    <= '0;
        end else begin
            if (state != SHIFT || fall) tmr <= '0;
            else                        tmr <= tmr + TW'(1);
            if (state == IDLE) begin
                bitcnt <= '0;
            end else if (state == SHIFT && fall) begin
                shreg  <= {dat_sync[1], shreg[9:1]};
                bitcnt <= bitcnt + 4'd1;
            end
        end
    end

    assign rx_byte = shreg[7:0];

endmodule

// File: rtl/ps2_mouse.sv
// PS/2 mouse controller: assembles 3-byte packets into a small FIFO and
// exposes DATA/STATUS registers plus a level interrupt on Wishbone.
module ps2_mouse
    import ps2_mouse_pkg::*;
#(
    parameter int CLKFREQ = 10000000,
    parameter int DEPTH   = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    if_wb.slave  bus,
    input  logic ps2_clock,
    input  logic ps2_data,
    output logic interrupt
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  rx_byte;
    logic        rx_good;
    logic        rx_bad;
    logic [1:0]  slot;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        push;
    logic        pop;
    logic        do_push;
    logic        full;
    pkt_t        push_pkt;
    pkt_t        mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0] count;
    logic        ovf;
    logic        err;
    logic        int_en;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        req;
    logic        wr_status;
    logic [31:0] rd_word;
    logic        unused_bits;

    ps2_rx_frame #(.CLKFREQ(CLKFREQ)) u_rx (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .good      (rx_good),
        .bad       (rx_bad)
    );

    // Packet assembler; bit3 of the first byte is always set, so use it to resync
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            slot <= 2'd0;
            b0   <= '0;
            b1   <= '0;
        end else if (rx_good) begin
            case (slot)
                2'd0: if (rx_byte[3]) begin
                    b0   <= rx_byte;
                    slot <= 2'd1;
                end
                2'd1: begin
                    b1   <= rx_byte;
                    slot <= 2'd2;
                end
                default: slot <= 2'd0;
            endcase
        end
    end

    assign push     = rx_good && slot == 2'd2;
    assign push_pkt = {rx_byte, b1, b0};
    assign full     = count == (AW + 1)'(DEPTH);
    assign req      = bus.cyc & bus.stb & ~ack_q;
    // Pop only what was actually handed out: dat_q[31] is the valid bit read
    assign pop      = ack_q & ~bus.we & (bus.adr[2] == REG_DATA) & dat_q[31];
    assign do_push  = push & (~full | pop);
    assign wr_status = ack_q & bus.we & (bus.adr[2] == REG_STATUS);

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= push_pkt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (pop)     rptr <= rptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ovf    <= 1'b0;
            err    <= 1'b0;
            int_en <= 1'b0;
        end else begin
            ovf <= (push & full & ~pop) | (ovf & ~(wr_status & bus.dat_i[ST_OVF]));
            err <= rx_bad | (err & ~(wr_status & bus.dat_i[ST_ERR]));
            if (wr_status) int_en <= bus.dat_i[ST_INT_EN];
        end
    end

    always_comb begin
        rd_word = '0;
        if (bus.adr[2] == REG_STATUS) begin
            rd_word[3:0]      = 4'(count);
            rd_word[ST_OVF]    = ovf;
            rd_word[ST_ERR]    = err;
            rd_word[ST_INT_EN] = int_en;
        end else if (count != '0) begin
            rd_word = {1'b1, 7'h0, mem[rptr]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            interrupt <= 1'b0;
        end else begin
            ack_q     <= req;
            dat_q     <= (req & ~bus.we) ? rd_word : '0;
            interrupt <= int_en & (count != '0);
        end
    end

    assign bus.ack   = ack_q;
    assign bus.dat_o = dat_q;

    assign unused_bits = ^{bus.sel, bus.adr[31:3], bus.adr[1:0],
                           bus.dat_i[31:9], bus.dat_i[7:6], bus.dat_i[3:0]};

endmodule

// File: tb/tb_ps2_mouse.sv
// Scoreboarded bench for ps2_mouse: PS/2 frames and Wishbone accesses are
// driven from directed vectors; expected read data is queued and checked on ack.
module tb_ps2_mouse;

    localparam int H = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clock = 1'b1;
    logic ps2_data = 1'b1;
    logic interrupt;

    if_wb bus();

    ps2_mouse #(.CLKFREQ(1000000), .DEPTH(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .bus       (bus),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data),
        .interrupt (interrupt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    string nm_q[$];

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: every read ack is compared against the head of the scoreboard
    always @(negedge clk) begin
        if (bus.ack && !bus.we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: got %h expected no read", bus.dat_o);
            end else begin
                check(nm_q.pop_front(), bus.dat_o, exp_q.pop_front());
            end
        end
    end

    task automatic wb_xfer(input logic we, input logic [31:0] a, input logic [31:0] d);
        bit got;
        got = 0;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we;
        bus.adr = a; bus.dat_i = d; bus.sel = 4'hf;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.ack) got = 1;
        end
        if (got) begin
            @(posedge clk); #1;
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: got no ack expected ack within 8 cycles");
            if (!we) begin
                void'(exp_q.pop_back());
                void'(nm_q.pop_back());
            end
        end
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    endtask

    task automatic wb_rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        exp_q.push_back(exp);
        nm_q.push_back(nm);
        wb_xfer(1'b0, a, 32'h0);
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
        wb_xfer(1'b1, a, d);
    endtask

    // One PS/2 bit; optionally start a DATA read timed so its ack lands on the
    // CHECK cycle of this (stop) bit
    task automatic ps2_bit(input logic b, input bit pop_here, input logic [31:0] pexp);
        ps2_data = b;
        repeat (H) @(posedge clk); #1 ps2_clock = 1'b0;
        if (pop_here) begin
            repeat (2) @(posedge clk); #1;
            wb_rd(32'h0, pexp, "sync_pop");
        end
        repeat (H) @(posedge clk); #1 ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par,
                              input bit pop_stop, input logic [31:0] pexp);
        logic [7:0] v;
        v = b;
        ps2_bit(1'b0, 0, 32'h0);
        for (int i = 0; i < 8; i++) ps2_bit(v[i], 0, 32'h0);
        ps2_bit((~^v) ^ bad_par, 0, 32'h0);
        ps2_bit(1'b1, pop_stop, pexp);
        repeat (20) @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 0, 0, 32'h0);
    endtask

    task automatic send_pkt(input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
        send_byte(x0);
        send_byte(x1);
        send_byte(x2);
    endtask

    task automatic send_partial();
        ps2_bit(1'b0, 0, 32'h0);
        ps2_bit(1'b1, 0, 32'h0);
        ps2_bit(1'b0, 0, 32'h0);
        ps2_bit(1'b1, 0, 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.adr = '0; bus.dat_i = '0; bus.sel = '0;
        repeat (4) @(posedge clk); #1;
        check("rst_irq", {31'h0, interrupt}, 32'h0);
        check("rst_ack", {31'h0, bus.ack}, 32'h0);
        check("rst_dat", bus.dat_o, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_rd(32'h4, 32'h0, "rst_status");
        wb_rd(32'h0, 32'h0, "rst_data_empty");

        // basic packet, then empty read
        send_pkt(8'h08, 8'h05, 8'hFB);
        wb_rd(32'h4, 32'h1, "pkt1_count");
        wb_rd(32'h0, 32'h80FB0508, "pkt1_data");
        wb_rd(32'h0, 32'h0, "pkt1_empty");
        wb_wr(32'h0, 32'hFFFFFFFF);
        wb_rd(32'h4, 32'h0, "data_write_ignored");

        // resync on bit3=0
        send_byte(8'h12);
        send_pkt(8'h09, 8'h01, 8'h02);
        wb_rd(32'h0, 32'h80020109, "resync_data");
        wb_rd(32'h4, 32'h0, "resync_status");

        // parity error
        send_frame(8'h08, 1, 0, 32'h0);
        wb_rd(32'h4, 32'h20, "parity_err");
        wb_wr(32'h4, 32'h20);
        wb_rd(32'h4, 32'h0, "err_cleared");

        // overflow
        for (int k = 1; k <= 5; k++) send_pkt(8'h08, 8'(8'h10 + k), 8'(k));
        wb_rd(32'h4, 32'h14, "ovf_status");
        wb_rd(32'h0, 32'h80011108, "ovf_head_p1");
        wb_rd(32'h0, 32'h80021208, "ovf_p2");
        wb_rd(32'h0, 32'h80031308, "ovf_p3");
        wb_rd(32'h0, 32'h80041408, "ovf_p4");
        wb_rd(32'h4, 32'h10, "ovf_sticky");
        wb_wr(32'h4, 32'h10);
        wb_rd(32'h4, 32'h0, "ovf_cleared");

        // pop and push on the same cycle while full
        for (int k = 1; k <= 4; k++) send_pkt(8'h08, 8'(8'h30 + k), 8'(8'h20 + k));
        wb_rd(32'h4, 32'h4, "full_status");
        send_byte(8'h08);
        send_byte(8'h35);
        send_frame(8'h25, 0, 1, 32'h80213108);
        wb_rd(32'h4, 32'h4, "sync_no_ovf");
        wb_rd(32'h0, 32'h80223208, "sync_q2");
        wb_rd(32'h0, 32'h80233308, "sync_q3");
        wb_rd(32'h0, 32'h80243408, "sync_q4");
        wb_rd(32'h0, 32'h80253508, "sync_q5");
        wb_rd(32'h4, 32'h0, "sync_drained");

        // timeout mid-frame
        send_partial();
        repeat (2100) @(posedge clk); #1;
        wb_rd(32'h4, 32'h20, "timeout_err");
        wb_wr(32'h4, 32'h20);
        send_pkt(8'h08, 8'h22, 8'h33);
        wb_rd(32'h0, 32'h80332208, "after_timeout");
        wb_rd(32'h4, 32'h0, "after_timeout_status");

        // interrupt
        wb_wr(32'h4, 32'h100);
        wb_rd(32'h4, 32'h100, "int_en_set");
        send_pkt(8'h08, 8'h44, 8'h55);
        check("irq_set", {31'h0, interrupt}, 32'h1);
        wb_rd(32'h4, 32'h101, "irq_status");
        wb_rd(32'h0, 32'h80554408, "irq_pkt");
        check("irq_hold", {31'h0, interrupt}, 32'h1);
        @(posedge clk); #1;
        check("irq_clear", {31'h0, interrupt}, 32'h0);

        // reset mid-frame
        send_pkt(8'h08, 8'h66, 8'h77);
        check("irq_before_rst", {31'h0, interrupt}, 32'h1);
        send_partial();
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_irq", {31'h0, interrupt}, 32'h0);
        check("midrst_ack", {31'h0, bus.ack}, 32'h0);
        check("midrst_dat", bus.dat_o, 32'h0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wb_rd(32'h4, 32'h0, "midrst_status");
        send_pkt(8'h08, 8'h19, 8'h2A);
        check("midrst_irq_off", {31'h0, interrupt}, 32'h0);
        wb_rd(32'h0, 32'h802A1908, "midrst_newpkt");
        wb_rd(32'h4, 32'h0, "midrst_final");

        repeat (5) @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_mouse.md
PS2_MOUSE -- requirements
Module: ps2_mouse

Interface
REQ-001 Parameter CLKFREQ, default 10000000, system clock frequency in Hz.
REQ-002 Parameter DEPTH, default 4, packet FIFO depth in entries; power of 2, minimum 2.
REQ-003 clk_i  input  1  system clock; all logic on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-low.
REQ-005 bus  if_wb.slave  -  Wishbone slave.
- Signals used: cyc, stb, we, adr, sel, dat_i (32), dat_o (32), ack.
- Attached to an IO-bus decoder port.
REQ-006 ps2_clock  input  1  PS/2 clock from the mouse (PS2_CLK2), asynchronous.
REQ-007 ps2_data  input  1  PS/2 data from the mouse (PS2_DAT2), asynchronous.
REQ-008 interrupt  output  1  level interrupt to the interrupt encoder.

Function
REQ-009 Synchronizer: ps2_clock and ps2_data each pass through a 2-flop synchronizer before use; a falling edge is the synchronized clock going 1 -> 0.
REQ-010 Frame receive FSM, states IDLE, SHIFT, CHECK.
- IDLE -> SHIFT on a falling edge with data=0 (start bit).
- SHIFT samples 8 data bits LSB-first, then parity, then stop, one bit per falling edge.
- CHECK runs for one cycle, then returns to IDLE.
REQ-011 Frame check: the byte is good when parity is odd over data+parity and stop=1; otherwise the frame is discarded and err is set.
REQ-012 Timeout: a counter reloads on every falling edge; after CLKFREQ/500 cycles (2 ms) with no edge in SHIFT, the FSM returns to IDLE, drops the partial frame and sets err.
REQ-013 Packet assembler: good bytes fill slots b0, b1, b2 in order.
- A byte offered to slot b0 with bit3=0 is dropped (resync) and the slot stays at b0.
- When b2 is filled, {b2,b1,b0} is pushed to the FIFO in the same cycle.
REQ-014 FIFO: DEPTH x 24 bits; count is clog2(DEPTH)+1 bits wide.
- Push when full drops the new packet and sets ovf; the stored contents are unchanged.
REQ-015 Register map, adr[2] selects the register; word access; sel is ignored.
- Offset 0 DATA (read): {valid, 7'h0, b2, b1, b0} of the FIFO head; valid=1 when non-empty.
- Offset 4 STATUS (read): [3:0] count, [4] ovf, [5] err, [8] int_en; all other bits 0.
- Offset 4 STATUS (write): dat_i[8] loads int_en; dat_i[4]=1 clears ovf; dat_i[5]=1 clears err.
- Writes to offset 0 are ignored.
REQ-016 Pop: a DATA read pops the FIFO only when it is non-empty. A DATA read on an empty FIFO returns 0 and leaves the FIFO unchanged.
REQ-017 Simultaneous push and pop on the same cycle are both performed, count is unchanged, and no overflow is flagged even when full.
REQ-018 Simultaneous set and clear of ovf or err on the same cycle: set wins.
REQ-019 Handshake: ack rises one cycle after cyc&stb is seen with ack low, and lasts exactly one cycle.
- dat_o is valid while ack is high.
- The pop and register write take effect on the ack cycle.
- Back-to-back accesses therefore ack every second cycle.
REQ-020 interrupt = int_en & (count != 0), registered, one cycle after the state changes.

Reset
REQ-021 While rst_i=0 at a clock edge, the following reset:
- FSM to IDLE; slot to b0.
- FIFO count and pointers to 0.
- ovf=0, err=0, int_en=0.
- ack=0, dat_o=0, interrupt=0.
- Synchronizer flops to 1.
REQ-022 Reset in the middle of a frame discards the partial frame; the first edges after release must see a new start bit.

Structure
REQ-023 A shared package holds the FSM state enum, the register offsets, the STATUS bit positions and the timeout divisor constant (500).
REQ-024 One sub-module, ps2_rx_frame, contains the synchronizer, the frame FSM and the timeout. It outputs a byte, a 1-cycle good strobe and a 1-cycle error strobe.
REQ-025 The FIFO is inline; no vendor memory macros are used.

Verification
REQ-026 Send bytes 0x08, 0x05, 0xFB with correct framing, then read DATA -> 0x80FB0508; a following read -> 0x00000000.
REQ-027 Send 0x12 (bit3=0) then 0x09, 0x01, 0x02 -> one packet, DATA=0x80020109; err=0.
REQ-028 Send byte 0x08 with even parity -> err=1, count=0; write STATUS 0x20 -> err=0.
REQ-029 With DEPTH=4, send 5 packets -> count=4, ovf=1, and the head is packet 1.
- With a pop and the 5th push on the same cycle: no ovf.
REQ-030 Send a start bit plus 3 bits, then hold the clock high for 2 ms -> err=1, FSM returns to IDLE, and the next full frame is received correctly.
REQ-031 Write STATUS 0x100, then push one packet -> interrupt=1. Pop it -> interrupt=0 two cycles after the ack. Assert rst_i=0 mid-frame -> all outputs read 0.
